// File: rtl/onehot_to_index_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_to_index_encoder
//  Description : Sequential 2^N-to-N encoder. Captures a decoded (one-hot or
//                multi-hot) word and emits the index of each set bit, lowest
//                first, one beat per output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_index_encoder #(
    parameter int N = 4,
    parameter int M = 2**N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] dec_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] enc_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         out_zero,
    output logic         busy
);

    localparam logic [0:0]   c_idle = 1'b0;
    localparam logic [0:0]   c_emit = 1'b1;
    localparam logic [M-1:0] c_one  = {{(M-1){1'b0}}, 1'b1};

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [M-1:0] r_pending;
    logic [M-1:0] w_pending_nxt;
    logic         r_zero_flag;
    logic         w_zero_nxt;
    logic [M-1:0] w_pending_dropped;
    logic [N-1:0] w_low_idx;
    logic         w_single;
    logic         w_emit;
    logic         w_last;

    // pending & (pending-1) clears the lowest set bit, which is also the
    // bit being emitted; the result being zero means only one bit was set.
    assign w_pending_dropped = r_pending & (r_pending - c_one);
    assign w_single          = (r_pending != '0) && (w_pending_dropped == '0);
    assign w_emit            = (r_state == c_emit);
    assign w_last            = w_single || r_zero_flag;

    always_comb begin
        w_low_idx = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = i[N-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_pending   <= '0;
            r_zero_flag <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_zero_flag <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_zero_nxt    = r_zero_flag;
        case (r_state)
            c_idle: begin
                if (in_valid) begin
                    w_pending_nxt = dec_in;
                    w_zero_nxt    = (dec_in == '0);
                    w_state_nxt   = c_emit;
                end
            end
            c_emit: begin
                if (out_ready) begin
                    w_pending_nxt = w_pending_dropped;
                    if (w_last) begin
                        w_state_nxt = c_idle;
                        w_zero_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = w_emit;
    assign busy      = w_emit;
    assign enc_out   = (w_emit && !r_zero_flag) ? w_low_idx : '0;
    assign out_last  = w_emit && w_last;
    assign out_zero  = w_emit && r_zero_flag;

endmodule
`default_nettype wire
